// File: rtl/uart_transmit.sv
// uart_transmit: byte-serialising UART transmitter (start, 8 data LSB first, stop).
// Bytes arrive over a valid/ready handshake into a small buffer and are framed onto txd.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry circular FIFO buffer;
// otherwise a single holding register is used and FIFO_DEPTH is ignored.
// tx_level is 3 bits wide, so FIFO_DEPTH is limited to 2 or 4.
module uart_transmit #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       txd,
    output logic       busy,
    output logic [2:0] tx_level
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_MAX = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    // Push is refused whenever full, even if a pop happens on the same edge.
    assign w_push     = data_valid && data_ready;
    assign data_ready = !w_full && !rst;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_head   = r_mem[r_rptr];
    assign tx_level = 3'(r_count);

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data_in;
    end

    // Pointers and occupancy; simultaneous push/pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [7:0]  r_hold;
    logic        r_hold_vld;
    logic [31:0] w_unused_depth;

    assign w_unused_depth = FIFO_DEPTH;
    assign w_full   = r_hold_vld;
    assign w_empty  = !r_hold_vld;
    assign w_head   = r_hold;
    assign tx_level = {2'b00, r_hold_vld};

    // Single holding register: push only when empty, pop only when occupied,
    // so the two can never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
        end else if (w_push) begin
            r_hold     <= data_in;
            r_hold_vld <= 1'b1;
        end else if (w_pop) begin
            r_hold_vld <= 1'b0;
        end
    end
`endif

    state_t        r_state, w_nxt_state;
    logic [BW-1:0] r_baud,  w_nxt_baud;
    logic [2:0]    r_bit,   w_nxt_bit;
    logic          r_stop,  w_nxt_stop;
    logic [7:0]    r_shift, w_nxt_shift;
    logic          r_txd,   w_nxt_txd;
    logic          w_baud_done;
    logic          w_last_stop;

    assign w_baud_done = (r_baud == BAUD_MAX);
    assign w_last_stop = (r_state == STOP) && w_baud_done && (r_stop == STOP_MAX);
    // Pop from idle, or straight from the final stop cycle for gapless frames.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_last_stop);

    assign txd  = r_txd;
    assign busy = (r_state != IDLE) || (tx_level != 3'd0);

    // Frame state register; reset aborts any frame and returns the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_baud  <= w_nxt_baud;
            r_bit   <= w_nxt_bit;
            r_stop  <= w_nxt_stop;
            r_shift <= w_nxt_shift;
            r_txd   <= w_nxt_txd;
        end
    end

    // Next-state and next-line logic; txd is registered so it changes with the state.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_baud  = w_baud_done ? '0 : BW'(r_baud + 1'b1);
        w_nxt_bit   = r_bit;
        w_nxt_stop  = r_stop;
        w_nxt_shift = r_shift;
        w_nxt_txd   = r_txd;
        case (r_state)
            IDLE: begin
                w_nxt_baud = '0;
                w_nxt_txd  = 1'b1;
                if (w_pop) begin
                    w_nxt_state = START;
                    w_nxt_shift = w_head;
                    w_nxt_txd   = 1'b0;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_nxt_state = DATA;
                    w_nxt_bit   = 3'd0;
                    w_nxt_txd   = r_shift[0];
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    if (r_bit == 3'd7) begin
                        w_nxt_state = STOP;
                        w_nxt_stop  = 1'b0;
                        w_nxt_txd   = 1'b1;
                    end else begin
                        w_nxt_shift = {1'b0, r_shift[7:1]};
                        w_nxt_txd   = r_shift[1];
                        w_nxt_bit   = r_bit + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    if (r_stop == STOP_MAX) begin
                        if (w_pop) begin
                            w_nxt_state = START;
                            w_nxt_shift = w_head;
                            w_nxt_txd   = 1'b0;
                        end else begin
                            w_nxt_state = IDLE;
                            w_nxt_txd   = 1'b1;
                        end
                    end else begin
                        w_nxt_stop = r_stop + 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_txd   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: scoreboard bench for uart_transmit. Accepted bytes are queued;
// a serial monitor decodes txd frames and compares each against the queue head.
module tb_uart_transmit;

`ifdef UART_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       data_ready, txd, busy;
    logic [2:0] tx_level;

    logic [7:0] data_in4 = '0;
    logic       data_valid4 = 1'b0;
    logic       data_ready4, txd4, busy4;
    logic [2:0] tx_level4;

    always #5 clk = ~clk;

    uart_transmit #(.CLKS_PER_BIT(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .txd(txd), .busy(busy), .tx_level(tx_level)
    );

    uart_transmit #(.CLKS_PER_BIT(4), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(data_in4), .data_valid(data_valid4),
        .data_ready(data_ready4), .txd(txd4), .busy(busy4), .tx_level(tx_level4)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    bit         mon_en = 1'b0;
    bit         lvl_en = 1'b0;
    int         max_lvl = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Serial monitor: one sample per clock on the falling edge.
    initial begin : mon
        logic [7:0] b;
        logic       sb;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && txd === 1'b0) begin
                start_q.push_back(cyc);
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    b[i] = txd;
                end
                @(negedge clk);
                sb = txd;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected frame: got %0h expected none", b);
                end else begin
                    chk("frame data", b, exp_q.pop_front());
                    chk("stop bit", sb, 1);
                end
            end
        end
    end

    // Ready must track occupancy exactly; also record the peak level.
    always @(negedge clk) begin
        if (lvl_en && !rst) begin
            chk("ready vs level", data_ready, (tx_level != CAP));
            if (tx_level > max_lvl) max_lvl = tx_level;
        end
    end

    task automatic push(input logic [7:0] b);
        int   t = 0;
        logic acc = 1'b0;
        data_in    = b;
        data_valid = 1'b1;
        while (!acc && t < 100) begin
            acc = data_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(b);
            @(negedge clk);
            t++;
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL push timeout: byte %0h not accepted", b);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain in time", (t < 1000), 1);
        @(negedge clk);
    endtask

    task automatic chk_gaps(input int n);
        chk("frame count", start_q.size(), n);
        for (int i = 1; i < start_q.size(); i++)
            chk("frame spacing", start_q[i] - start_q[i-1], 10);
        start_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [9:0]  exp_a5;
        logic [9:0]  seq;
        logic [43:0] exp_81;
        logic [43:0] seq4;
        bit          all_busy;
        bit          all_idle;
        exp_a5 = 10'b1101001010;        // bit i = txd i+1 cycles after accept
        exp_81 = 44'hFFF_0000_00F0;     // start x4, 1 x4, 0 x24, 1 x4, stop x8

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ready", data_ready, 0);
        chk("reset txd", txd, 1);
        chk("reset busy", busy, 0);
        chk("reset level", tx_level, 0);
        chk("reset txd4", txd4, 1);
        rst = 1'b0;
        #1;
        chk("ready after reset", data_ready, 1);
        mon_en = 1'b1;
        lvl_en = 1'b1;

        // Single byte 0xA5, exact line sequence
        @(negedge clk);
        push(8'hA5);
        data_valid = 1'b0;
        chk("a5 busy at accept", busy, 1);
        chk("a5 level at accept", tx_level, 1);
        chk("a5 txd at accept", txd, 1);
        all_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seq[i] = txd;
            all_busy &= busy;
        end
        chk("a5 line sequence", seq, exp_a5);
        chk("a5 busy during frame", all_busy, 1);
        @(negedge clk);
        chk("a5 txd after frame", txd, 1);
        chk("a5 busy after frame", busy, 0);
        drain();
        chk_gaps(1);

        // Back-to-back with valid held: 0x00, 0xFF, 0x3C
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        data_valid = 1'b0;
        drain();
        chk_gaps(3);

        // Seven distinct bytes, valid held; buffer fills to capacity
        max_lvl = 0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55); push(8'h66); push(8'h77);
        data_valid = 1'b0;
        drain();
        chk("peak level", max_lvl, CAP);
        chk_gaps(7);

        // CLKS_PER_BIT=4, STOP_BITS=2 instance, byte 0x81
        data_in4    = 8'h81;
        data_valid4 = 1'b1;
        chk("dut4 ready", data_ready4, 1);
        @(posedge clk);
        @(negedge clk);
        data_valid4 = 1'b0;
        all_busy = 1'b1;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            seq4[i] = txd4;
            all_busy &= busy4;
        end
        chk("dut4 line sequence", seq4, exp_81);
        chk("dut4 busy during frame", all_busy, 1);
        @(negedge clk);
        chk("dut4 txd after frame", txd4, 1);
        chk("dut4 busy after frame", busy4, 0);

        // Reset mid-DATA of 0x55 with bytes queued behind it
        mon_en = 1'b0;
        push(8'h55);
        push(8'h11);
`ifdef UART_TX_FIFO_EN
        push(8'h22);
`endif
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queued before reset", tx_level, (CAP > 1) ? 2 : 1);
        rst = 1'b1;
        #1;
        chk("ready during reset", data_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("txd after mid reset", txd, 1);
        chk("level after mid reset", tx_level, 0);
        chk("busy after mid reset", busy, 0);
        exp_q.delete();
        start_q.delete();
        all_idle = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            all_idle &= txd & !busy;
        end
        chk("no frame resumes", all_idle, 1);
        mon_en = 1'b1;
        push(8'h0F);
        data_valid = 1'b0;
        drain();
        chk_gaps(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
